// File: rtl/wb_sample_buf_pkg.sv
// Shared constants for the Wishbone sample buffer: register map, bit positions
// and the checksum engine state encoding.
package wb_sample_buf_pkg;

    localparam int unsigned ADDR_CTRL   = 32'h000;
    localparam int unsigned ADDR_STATUS = 32'h001;
    localparam int unsigned ADDR_COUNT  = 32'h002;
    localparam int unsigned ADDR_SUM    = 32'h003;
    localparam int unsigned BUF_BASE    = 32'h400;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wb_sample_buf_if.sv
// Wishbone pipelined-mode bus between the DEPP bridge (master) and the sample buffer (slave).
interface wb_sample_buf_if #(
    parameter int AW = 30
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic          stall;
    logic          err;
    logic [31:0]   rdata;

    modport master (
        output cyc, stb, we, addr, wdata,
        input  ack, stall, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata,
        output ack, stall, err, rdata
    );
endinterface

// File: rtl/wb_sample_buf_sp_ram.sv
// Single-port synchronous RAM, 32-bit words, registered read (read-before-write).
module sp_ram #(
    parameter int DEPTH = 256,
    parameter int LD    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [LD-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/wb_sample_buf.sv
// Wishbone slave holding a sample buffer, a small register file and a checksum
// engine that sums the first COUNT buffered words and raises o_int when done.
module wb_sample_buf
    import wb_sample_buf_pkg::*;
#(
    parameter int AW    = 30,
    parameter int DEPTH = 256
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_sample_buf_if.slave wb,
    output logic           o_int
);
    localparam int LDEPTH = $clog2(DEPTH);
    localparam logic [AW-LDEPTH-1:0] BUF_TAG = (AW-LDEPTH)'(BUF_BASE >> LDEPTH);
    localparam logic [LDEPTH:0]      N_MAX   = (LDEPTH+1)'(DEPTH);

    state_t            state_reg;
    logic [LDEPTH:0]   cnt_reg;
    logic [LDEPTH:0]   n_reg;
    logic [LDEPTH:0]   count_reg;
    logic [31:0]       sum_reg;
    logic              done_reg, done_next;
    logic              irq_en_reg, irq_en_next;
    logic              int_reg;
    logic              ack_reg, err_reg, buf_rd_reg;
    logic [31:0]       reg_rd_reg, reg_rd;

    logic is_ctrl, is_status, is_count, is_sum, is_buf, is_valid;
    logic stall, accept, wr, start_ok, busy;
    logic              ram_we;
    logic [LDEPTH-1:0] ram_addr;
    logic [31:0]       ram_q;

    assign is_ctrl   = (wb.addr == AW'(ADDR_CTRL));
    assign is_status = (wb.addr == AW'(ADDR_STATUS));
    assign is_count  = (wb.addr == AW'(ADDR_COUNT));
    assign is_sum    = (wb.addr == AW'(ADDR_SUM));
    assign is_buf    = (wb.addr[AW-1:LDEPTH] == BUF_TAG);
    assign is_valid  = is_ctrl | is_status | is_count | is_sum | is_buf;

    assign busy     = (state_reg == RUN);
    assign stall    = busy & is_buf;
    assign accept   = wb.cyc & wb.stb & ~stall;
    assign wr       = accept & wb.we & is_valid;
    assign start_ok = wr & is_ctrl & wb.wdata[CTRL_START_BIT] & ~busy;

    // The engine owns the RAM port while running; buffer requests are stalled then.
    assign ram_addr = busy ? cnt_reg[LDEPTH-1:0] : wb.addr[LDEPTH-1:0];
    assign ram_we   = ~busy & wr & is_buf;

    sp_ram #(.DEPTH(DEPTH), .LD(LDEPTH)) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wb.wdata),
        .q     (ram_q)
    );

    always_comb begin
        reg_rd = 32'h0;
        if (is_ctrl) begin
            reg_rd[CTRL_IRQ_EN_BIT] = irq_en_reg;
        end else if (is_status) begin
            reg_rd[STAT_BUSY_BIT] = busy;
            reg_rd[STAT_DONE_BIT] = done_reg;
        end else if (is_count) begin
            reg_rd = 32'(count_reg);
        end else if (is_sum) begin
            reg_rd = sum_reg;
        end
    end

    // Completion set outranks a same-cycle write-1-to-clear.
    always_comb begin
        done_next = done_reg;
        if (wr && is_status && wb.wdata[STAT_DONE_BIT]) begin
            done_next = 1'b0;
        end
        if (start_ok) begin
            done_next = 1'b0;
        end else if (state_reg == DONE) begin
            done_next = 1'b1;
        end
        irq_en_next = (wr && is_ctrl) ? wb.wdata[CTRL_IRQ_EN_BIT] : irq_en_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            buf_rd_reg <= 1'b0;
            reg_rd_reg <= 32'h0;
        end else begin
            ack_reg    <= accept & is_valid;
            err_reg    <= accept & ~is_valid;
            buf_rd_reg <= accept & is_buf & ~wb.we;
            if (accept && !wb.we && is_valid && !is_buf) begin
                reg_rd_reg <= reg_rd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            n_reg      <= '0;
            count_reg  <= '0;
            sum_reg    <= 32'h0;
            done_reg   <= 1'b0;
            irq_en_reg <= 1'b0;
            int_reg    <= 1'b0;
        end else begin
            done_reg   <= done_next;
            irq_en_reg <= irq_en_next;
            int_reg    <= done_next & irq_en_next;
            if (wr && is_count) begin
                count_reg <= wb.wdata[LDEPTH:0];
            end
            if (start_ok) begin
                state_reg <= RUN;
                sum_reg   <= 32'h0;
                cnt_reg   <= '0;
                n_reg     <= (count_reg > N_MAX) ? N_MAX : count_reg;
            end else begin
                case (state_reg)
                    RUN: begin
                        // RAM data lags the address by one cycle, so cnt k adds word k-1.
                        if (cnt_reg != '0) begin
                            sum_reg <= sum_reg + ram_q;
                        end
                        if (cnt_reg == n_reg) begin
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    DONE:    state_reg <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign wb.stall = stall;
    assign wb.ack   = ack_reg & wb.cyc;
    assign wb.err   = err_reg & wb.cyc;
    assign wb.rdata = buf_rd_reg ? ram_q : reg_rd_reg;
    assign o_int    = int_reg;

endmodule
